// File: rtl/ram_fifo_ctrl_if.sv
// FIFO-side handshake bundle for ram_fifo_ctrl.
// almost_full exists only when RAM_FIFO_AFULL_EN is defined.
interface ram_fifo_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_req;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
`ifdef RAM_FIFO_AFULL_EN
    logic              almost_full;
`endif

    modport master (
        output wr_valid, wr_data, rd_req,
        input  wr_ready, rd_valid, rd_data, full, empty, count
`ifdef RAM_FIFO_AFULL_EN
        , input almost_full
`endif
    );

    modport slave (
        input  wr_valid, wr_data, rd_req,
        output wr_ready, rd_valid, rd_data, full, empty, count
`ifdef RAM_FIFO_AFULL_EN
        , output almost_full
`endif
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller wrapping a 64x8 dual-port RAM (port A write, port B registered read).
// Optional registered almost_full output under RAM_FIFO_AFULL_EN.
module ram_fifo_ctrl #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned AF_LEVEL = 56
) (
    input  logic              clk,
    input  logic              rst,
    ram_fifo_ctrl_if.slave    fifo,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [DATA_W-1:0] ram_din_a,
    output logic              ram_we_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [DATA_W-1:0] ram_din_b,
    output logic              ram_we_b,
    input  logic [DATA_W-1:0] ram_dout_b
);
    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    // Threshold above the depth could never be reached.
    if (AF_LEVEL > DEPTH) begin : g_af_level_check
        $error("ram_fifo_ctrl: AF_LEVEL exceeds FIFO depth");
    end

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W-1:0] count_q, count_d;
    logic             rd_valid_q;
    logic             full_c, empty_c, push, pop;

    // Extra pointer MSB distinguishes full from empty when the addresses match.
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {ADDR_W{1'b0}}});

    assign push = fifo.wr_valid & ~full_c;
    assign pop  = fifo.rd_req & ~empty_c;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + PTR_W'(1);
            2'b01:   count_d = count_q - PTR_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q    <= count_d;
            rd_valid_q <= pop;
        end
    end

`ifdef RAM_FIFO_AFULL_EN
    logic af_q;

    always_ff @(posedge clk) begin
        if (rst) af_q <= 1'b0;
        else     af_q <= (count_d >= PTR_W'(AF_LEVEL));
    end

    assign fifo.almost_full = af_q;
`endif

    assign fifo.wr_ready = ~full_c;
    assign fifo.rd_valid = rd_valid_q;
    assign fifo.rd_data  = ram_dout_b;
    assign fifo.full     = full_c;
    assign fifo.empty    = empty_c;
    assign fifo.count    = count_q;

    assign ram_addr_a = wr_ptr_q[ADDR_W-1:0];
    assign ram_din_a  = fifo.wr_data;
    assign ram_we_a   = push;
    assign ram_addr_b = rd_ptr_q[ADDR_W-1:0];
    assign ram_din_b  = '0;
    assign ram_we_b   = 1'b0;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural RAM and a data scoreboard.
module tb_ram_fifo_ctrl;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned AF_LVL = 56;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] ram_addr_a, ram_addr_b;
    logic [DATA_W-1:0] ram_din_a, ram_din_b, ram_dout_b;
    logic              ram_we_a, ram_we_b;
    logic [DATA_W-1:0] mem [DEPTH];

    ram_fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) fif ();

    ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_LEVEL(AF_LVL)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo       (fif.slave),
        .ram_addr_a (ram_addr_a),
        .ram_din_a  (ram_din_a),
        .ram_we_a   (ram_we_a),
        .ram_addr_b (ram_addr_b),
        .ram_din_b  (ram_din_b),
        .ram_we_b   (ram_we_b),
        .ram_dout_b (ram_dout_b)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: write on port A, registered read on port B.
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
        ram_dout_b <= mem[ram_addr_b];
    end

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned m_count = 0;
    int unsigned m_wp = 0;
    int unsigned m_rp = 0;
    logic        pend_pop = 1'b0;
    logic [DATA_W-1:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: check registered state, drive inputs, check combinational outputs, clock.
    task automatic step(input logic wv, input logic [DATA_W-1:0] wd, input logic rr, input logic r);
        logic push_ok, pop_ok;
        logic [DATA_W-1:0] exp_d;
        chk("count", 32'(fif.count), 32'(m_count));
        chk("empty", 32'(fif.empty), 32'(m_count == 0));
        chk("full", 32'(fif.full), 32'(m_count == DEPTH));
        chk("wr_ready", 32'(fif.wr_ready), 32'(m_count != DEPTH));
        chk("rd_valid", 32'(fif.rd_valid), 32'(pend_pop));
        chk("ram_addr_a", 32'(ram_addr_a), m_wp % DEPTH);
        chk("ram_addr_b", 32'(ram_addr_b), m_rp % DEPTH);
`ifdef RAM_FIFO_AFULL_EN
        chk("almost_full", 32'(fif.almost_full), 32'(m_count >= AF_LVL));
`endif
        if (pend_pop) begin
            exp_d = sb.pop_front();
            chk("rd_data", 32'(fif.rd_data), 32'(exp_d));
        end
        fif.wr_valid = wv;
        fif.wr_data  = wd;
        fif.rd_req   = rr;
        rst          = r;
        push_ok = wv && (m_count != DEPTH);
        pop_ok  = rr && (m_count != 0);
        #1;
        chk("ram_we_a", 32'(ram_we_a), 32'(push_ok));
        if (push_ok) begin
            chk("ram_din_a", 32'(ram_din_a), 32'(wd));
            sb.push_back(wd);
        end
        @(posedge clk);
        if (r) begin
            m_count = 0; m_wp = 0; m_rp = 0; pend_pop = 1'b0;
            sb.delete();
        end else begin
            if (push_ok) m_wp = (m_wp + 1) % (2 * DEPTH);
            if (pop_ok)  m_rp = (m_rp + 1) % (2 * DEPTH);
            if (push_ok && !pop_ok) m_count++;
            if (pop_ok && !push_ok) m_count--;
            pend_pop = pop_ok;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic push_seq(input int n, input logic [DATA_W-1:0] base);
        for (int i = 0; i < n; i++) step(1'b1, base + DATA_W'(i), 1'b0, 1'b0);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        fif.wr_valid = 1'b0;
        fif.wr_data  = '0;
        fif.rd_req   = 1'b0;
        rst          = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("ram_we_b", 32'(ram_we_b), 32'd0);
        chk("ram_din_b", 32'(ram_din_b), 32'd0);

        // Three pushes, three pops.
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        pop_n(3);
        idle(2);

        // Fill to full, rejected 65th push, drain in order.
        push_seq(64, 8'h00);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        pop_n(64);
        idle(2);

        // Steady push+pop at 60 entries across pointer wrap.
        push_seq(60, 8'h40);
        for (int i = 0; i < 200; i++) step(1'b1, DATA_W'($urandom), 1'b1, 1'b0);
        pop_n(60);
        idle(2);

        // Pop on empty with simultaneous push is dropped.
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle(2);

        // Push+pop at full takes only the pop.
        push_seq(64, 8'h80);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        pop_n(63);
        idle(2);

        // Cross the almost-full threshold both ways, then reset during a pop.
        push_seq(57, 8'h10);
        pop_n(3);
        push_seq(2, 8'hC0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        idle(3);
        push_seq(2, 8'h5A);
        pop_n(2);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Synchronous FIFO controller that drives the 64x8 dual-port RAM, turning it into a first-in first-out buffer. Port A of the RAM is used only for writes (push) and port B only for reads (pop). The controller owns the write/read pointers, occupancy count, full/empty flags and read-valid tracking. It sits directly upstream of the RAM: it feeds the RAM's address, data and write-enable inputs and consumes its registered port-B read data.

## Interface
- DATA_W, 8, data width; matches RAM word width.
- ADDR_W, 6, RAM address width; depth = 2**ADDR_W = 64.
- AF_LEVEL, 56, almost-full threshold in entries (used only with RAM_FIFO_AFULL_EN).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  push request.
- wr_data  in  DATA_W  push data.
- wr_ready  out  1  push accepted when wr_valid & wr_ready; equals !full.
- rd_req  in  1  pop request; ignored when empty.
- rd_valid  out  1  rd_data holds popped word this cycle.
- rd_data  out  DATA_W  popped word; wired from ram_dout_b.
- full  out  1  count == 2**ADDR_W.
- empty  out  1  count == 0.
- count  out  ADDR_W+1  occupancy, 0..64.
- almost_full  out  1  only with RAM_FIFO_AFULL_EN.
- ram_addr_a  out  ADDR_W  RAM port-A address (write pointer).
- ram_din_a  out  DATA_W  RAM port-A write data (= wr_data).
- ram_we_a  out  1  RAM port-A write enable.
- ram_addr_b  out  ADDR_W  RAM port-B address (read pointer).
- ram_din_b  out  DATA_W  tied 0.
- ram_we_b  out  1  tied 0.
- ram_dout_b  in  DATA_W  RAM port-B registered read data.

## Operation
- Pointers wr_ptr and rd_ptr are ADDR_W+1 bits wide. The RAM address is the low ADDR_W bits. Both wrap modulo 2**(ADDR_W+1).
- Push accepted (push) = wr_valid & !full. When push is true, ram_we_a = 1 and wr_ptr increments at the clock edge. ram_we_a must be combinationally 0 when full.
- Pop accepted (pop) = rd_req & !empty. When pop is true, rd_ptr increments at the clock edge. ram_addr_b always presents the current rd_ptr.
- rd_req while empty is dropped: no pointer change and no rd_valid.
- count update: +1 on push only, −1 on pop only, unchanged when both or neither.
- full, empty and count are registered-state-derived. A word pushed in cycle N becomes poppable in cycle N+1.
  - Consequence: port A and port B never address the same live entry in the same cycle while that entry is being written.
  - The RAM's old-data-on-collision behaviour is therefore never observable, and no bypass path exists.
- Simultaneous push and pop:
  - When full, only the pop is taken; wr_ready = 0.
  - When empty, only the push is taken; the pop is dropped.
- No internal state machine beyond the pointers, count and rd_valid register.

## Timing
- Read latency is 1 cycle: a pop accepted in cycle N yields rd_valid = 1 and valid rd_data in cycle N+1.
- Back-to-back pops give one word per cycle.
- Push latency: a word accepted in cycle N is written at the N→N+1 edge. empty deasserts and count updates in cycle N+1.
- rd_valid is a register: rd_valid ← pop.
- Reset (rst high at a rising edge):
  - wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, wr_ready = 1, rd_valid = 0, almost_full = 0.
  - Applies even if a push or pop is in flight; that pop's rd_valid is suppressed.
  - RAM contents are not cleared.
- rd_data is only meaningful when rd_valid = 1.

## Configuration
- RAM_FIFO_AFULL_EN defined:
  - Adds a registered almost_full output, asserted when count ≥ AF_LEVEL and updated with count.
  - Value is 0 at reset.
- RAM_FIFO_AFULL_EN undefined:
  - The almost_full port and its logic are absent.
  - AF_LEVEL is unused.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles, then pop 3 times -> rd_valid high for 3 cycles, rd_data 0x11, 0x22, 0x33; empty = 1 and count = 0 afterwards.
- Push 64 words 0x00..0x3F -> full = 1, count = 64, wr_ready = 0. A 65th push (0xFF) does not assert ram_we_a. Popping all 64 returns 0x00..0x3F in order.
- Fill 60 words, then pop one and push one every cycle for 200 cycles (pointer wrap) -> count stays 60 and data order is preserved across the wrap.
- Push 0xA5 at cycle N while asserting rd_req at cycle N on an empty FIFO -> the pop is dropped and there is no rd_valid in N+1. rd_req at N+1 gives rd_valid at N+2 with 0xA5.
- At full, assert wr_valid and rd_req together -> only the pop is taken, count = 63, and the oldest word is output.
- Assert rst mid-stream, in the cycle a pop is accepted -> rd_valid = 0 next cycle, count = 0, empty = 1. With RAM_FIFO_AFULL_EN defined: almost_full toggles at count 55→56 and back.
